lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl_pkg.sv | 21 ++
 rtl/lock_timer.sv | 35 +++
 rtl/lock_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lock_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_ctrl_pkg.sv
// Shared types for the keypad lock controller.
// State encoding and BCD digit helpers.
package lock_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        SAVE    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam int   SAVE_WAIT = 4;

    function automatic logic is_bcd(input bcd_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a zero flag.
// Holds at zero once it gets there.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lock_ctrl.sv
// Keypad entry buffer, password compare and lockout sequencing
// that sits in front of an external lock FSM.
module lock_ctrl
    import lock_ctrl_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic                           clk,
    input  logic                           RESETN,
    input  logic                           key_valid,
    input  logic [3:0]                     key_digit,
    input  logic                           clr,
    input  logic                           enter,
    input  logic                           LOCKED,
    input  logic                           savePW,
    input  logic                           saveAT,
    output logic                           E,
    output logic                           M,
    output logic                           lockout,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
    output logic [$clog2(DIGITS+1)-1:0]    digit_cnt
);

    localparam int BW = DIGITS * 4;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [CW-1:0] FULL   = CW'(DIGITS);
    localparam logic [FW-1:0] FLIMIT = FW'(MAX_FAILS);
    localparam logic [TW-1:0] TLOAD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    SLAST  = 2'(SAVE_WAIT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [BW-1:0] pw_q, pw_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [1:0]    save_q, save_d;
    logic          match_q, match_d;
    logic          enter_q;

    logic          rise;
    logic          take;
    logic [FW-1:0] fail_inc;
    logic          tmr_load;
    logic          tmr_dec;
    logic          tmr_zero;

    // LOCKED is consumed by the lock FSM itself; nothing here depends on it.
    logic unused_locked;
    assign unused_locked = LOCKED;

    assign rise     = enter & ~enter_q;
    assign take     = key_valid & is_bcd(key_digit) & (cnt_q != FULL);
    assign fail_inc = fail_q + FW'(1);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        pw_d     = pw_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        save_d   = save_q;
        match_d  = match_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else begin
                    if (take) begin
                        buf_d = {buf_q[BW-5:0], key_digit};
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (rise && (cnt_q == FULL)) begin
                        state_d = PULSE;
                    end
                end
            end
            PULSE: begin
                match_d = (buf_q == pw_q);
                save_d  = '0;
                state_d = SAVE;
                if (clr) begin
                    buf_d = '0;
                    cnt_d = '0;
                end
            end
            SAVE: begin
                save_d = save_q + 2'd1;
                if (savePW) begin
                    pw_d    = buf_q;
                    fail_d  = '0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (saveAT) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (match_q) begin
                        fail_d = '0;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == FLIMIT) begin
                            state_d  = LOCKOUT;
                            tmr_load = 1'b1;
                        end
                    end
                end else if (save_q == SLAST) begin
                    state_d = IDLE;
                end else if (clr) begin
                    buf_d = '0;
                    cnt_d = '0;
                end
            end
            LOCKOUT: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
            buf_q   <= '0;
            pw_q    <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            save_q  <= '0;
            match_q <= 1'b0;
            enter_q <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pw_q    <= pw_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            save_q  <= save_d;
            match_q <= match_d;
            enter_q <= enter;
        end
    end

    lock_timer #(
        .W(TW)
    ) u_timer (
        .clk   (clk),
        .rst_n (RESETN),
        .load_i(tmr_load),
        .val_i (TLOAD),
        .dec_i (tmr_dec),
        .zero_o(tmr_zero)
    );

    assign E         = (state_q == PULSE);
    assign M         = match_q;
    assign lockout   = (state_q == LOCKOUT);
    assign fail_cnt  = fail_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed scoreboard bench for lock_ctrl.
// Expectations are queued as stimulus is driven and popped at each check.
module tb_lock_ctrl;

    localparam int DIGITS = 4;
    localparam int MAX_FAILS = 3;
    localparam int LOCKOUT_CYCLES = 10;

    logic       clk = 1'b0;
    logic       RESETN = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       clr = 1'b0;
    logic       enter = 1'b0;
    logic       LOCKED = 1'b0;
    logic       savePW = 1'b0;
    logic       saveAT = 1'b0;
    logic       E, M, lockout;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;

    int ncmp = 0;
    int nfail = 0;
    string tagq[$];
    int    expq[$];

    always #5 clk = ~clk;

    lock_ctrl #(
        .DIGITS(DIGITS),
        .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk), .RESETN(RESETN),
        .key_valid(key_valid), .key_digit(key_digit),
        .clr(clr), .enter(enter), .LOCKED(LOCKED),
        .savePW(savePW), .saveAT(saveAT),
        .E(E), .M(M), .lockout(lockout),
        .fail_cnt(fail_cnt), .digit_cnt(digit_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input int v);
        tagq.push_back(tag);
        expq.push_back(v);
    endtask

    task automatic got(input int obs);
        string t;
        int e;
        ncmp++;
        if (expq.size() == 0) begin
            nfail++;
            $error("FAIL scoreboard_empty: got %0d required an expectation", obs);
        end else begin
            t = tagq.pop_front();
            e = expq.pop_front();
            assert (obs === e) else begin
                nfail++;
                $error("FAIL %s: got %0d required %0d", t, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input int exp_v, input int obs);
        expect_v(tag, exp_v);
        got(obs);
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic keys4(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) key(code[i*4 +: 4]);
    endtask

    // Enter held for two cycles: E must be high after the first edge only.
    task automatic press(input string tag, input int exp_m);
        enter = 1'b1;
        expect_v({tag, "_E1"}, 1);
        tick();
        got(int'(E));
        expect_v({tag, "_E0"}, 0);
        tick();
        got(int'(E));
        enter = 1'b0;
        chk({tag, "_M"}, exp_m, int'(M));
    endtask

    task automatic strobe_at();
        saveAT = 1'b1;
        tick();
        saveAT = 1'b0;
    endtask

    task automatic strobe_pw();
        savePW = 1'b1;
        tick();
        savePW = 1'b0;
    endtask

    initial begin
        int lo;
        #2;
        chk("rst_E", 0, int'(E));
        chk("rst_M", 0, int'(M));
        chk("rst_lockout", 0, int'(lockout));
        chk("rst_fail", 0, int'(fail_cnt));
        chk("rst_digits", 0, int'(digit_cnt));
        #20 RESETN = 1'b1;
        tick();

        keys4(16'h1234);
        chk("setpw_digits", 4, int'(digit_cnt));
        press("setpw", 0);
        strobe_pw();
        chk("setpw_cleared", 0, int'(digit_cnt));
        chk("setpw_fail", 0, int'(fail_cnt));

        keys4(16'h1234);
        press("good", 1);
        strobe_at();
        chk("good_fail", 0, int'(fail_cnt));
        chk("good_digits", 0, int'(digit_cnt));

        key(4'd5);
        key(4'd6);
        enter = 1'b1;
        expect_v("short_E_a", 0);
        tick();
        got(int'(E));
        expect_v("short_E_b", 0);
        tick();
        got(int'(E));
        enter = 1'b0;
        chk("short_digits", 2, int'(digit_cnt));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("short_clr", 0, int'(digit_cnt));

        for (int d = 1; d <= 6; d++) key(4'(d));
        chk("sat_digits", 4, int'(digit_cnt));
        press("sat", 1);
        strobe_at();
        chk("sat_fail", 0, int'(fail_cnt));

        key(4'd7);
        key(4'd8);
        key(4'd9);
        chk("clr3_pre", 3, int'(digit_cnt));
        clr = 1'b1;
        key(4'd5);
        clr = 1'b0;
        chk("clr_wins", 0, int'(digit_cnt));
        key(4'hB);
        chk("nonbcd_ignored", 0, int'(digit_cnt));
        key(4'd0);
        chk("zero_accepted", 1, int'(digit_cnt));
        clr = 1'b1;
        tick();
        clr = 1'b0;

        keys4(16'h1234);
        press("tmo", 1);
        key(4'd7);
        for (int i = 0; i < 3; i++) tick();
        chk("tmo_digits", 4, int'(digit_cnt));
        chk("tmo_fail", 0, int'(fail_cnt));
        press("tmo_again", 1);
        strobe_at();
        chk("tmo_done", 0, int'(digit_cnt));

        for (int a = 1; a <= 2; a++) begin
            keys4(16'h9999);
            press("bad", 0);
            strobe_at();
            chk("bad_fail", a, int'(fail_cnt));
            chk("bad_lockout", 0, int'(lockout));
        end
        keys4(16'h9999);
        press("bad3", 0);
        strobe_at();
        chk("lock_fail3", 3, int'(fail_cnt));
        lo = 0;
        for (int i = 0; i < 40 && lockout; i++) begin
            lo++;
            key_valid = 1'b1;
            key_digit = 4'd3;
            enter = ~enter;
            tick();
        end
        key_valid = 1'b0;
        enter = 1'b0;
        chk("lock_len", LOCKOUT_CYCLES, lo);
        chk("lock_keys_ignored", 0, int'(digit_cnt));
        chk("lock_fail_clr", 0, int'(fail_cnt));
        tick();

        for (int a = 0; a < 3; a++) begin
            keys4(16'h9999);
            press("rl", 0);
            strobe_at();
        end
        tick();
        chk("rl_in_lock", 1, int'(lockout));
        #2 RESETN = 1'b0;
        #1;
        chk("rl_lockout", 0, int'(lockout));
        chk("rl_fail", 0, int'(fail_cnt));
        chk("rl_E", 0, int'(E));
        #10 RESETN = 1'b1;
        tick();
        key(4'd3);
        chk("rl_keys_ok", 1, int'(digit_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, required completion");
        $fatal(1, "watchdog");
    end

endmodule
